parking_pass_keypad: RTL and testbench

//  Upstream stage of the car-park gate FSM: debounces a raw 2-bit keypad and assembles two digits.

---
 rtl/parking_pass_keypad.sv | 204 ++++++++++++++++++++
 tb/tb_parking_pass_keypad.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_pass_keypad.sv
// parking_pass_keypad: syncs and debounces a raw keypad, assembles two digits for the gate FSM.
// Defining LOCKOUT_EN adds a reject counter and a timed LOCKED state.
module parking_pass_keypad #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int MAX_TRIES       = 3,
    parameter int LOCK_CYCLES     = 128
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_entrance,
    input  logic       key_press,
    input  logic [1:0] key_code,
    input  logic       key_clear,
    input  logic       pass_accept,
    input  logic       pass_reject,
    output logic [1:0] pass1,
    output logic [1:0] pass2,
    output logic       pass_valid,
    output logic [1:0] digit_cnt,
    output logic       locked
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || MAX_TRIES < 1 || LOCK_CYCLES < 1) begin : g_bad_cfg
            $error("parking_pass_keypad: cycle and try parameters must be at least 1");
        end
    endgenerate

`ifdef LOCKOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_EMPTY, S_ONE, S_READY, S_LOCKED} state_t;
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LK_W   = $clog2(LOCK_CYCLES + 1);
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [LK_W-1:0]   lock_q, lock_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_EMPTY, S_ONE, S_READY} state_t;
`endif

    logic            kp_s1_q, kp_s2_q;
    logic [1:0]      kc_s1_q, kc_s2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            evt_q, evt_d;
    logic [1:0]      evt_code_q;
    state_t          state_q, state_d;
    logic [1:0]      p1_q, p1_d, p2_q, p2_d;
    logic [TO_W-1:0] tmo_q, tmo_d;
    logic            tmo_hit;

    // Run-length counter saturates at DEBOUNCE_CYCLES so a held key fires exactly once.
    always_comb begin
        db_cnt_d = db_cnt_q;
        if (!kp_s2_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DB_W'(DEBOUNCE_CYCLES)) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
        evt_d = kp_s2_q && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kp_s1_q    <= 1'b0;
            kp_s2_q    <= 1'b0;
            kc_s1_q    <= '0;
            kc_s2_q    <= '0;
            db_cnt_q   <= '0;
            evt_q      <= 1'b0;
            evt_code_q <= '0;
            state_q    <= S_IDLE;
            p1_q       <= '0;
            p2_q       <= '0;
            tmo_q      <= '0;
        end else begin
            kp_s1_q    <= key_press;
            kp_s2_q    <= kp_s1_q;
            kc_s1_q    <= key_code;
            kc_s2_q    <= kc_s1_q;
            db_cnt_q   <= db_cnt_d;
            evt_q      <= evt_d;
            evt_code_q <= kc_s2_q;
            state_q    <= state_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            tmo_q      <= tmo_d;
        end
    end

`ifdef LOCKOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_q <= '0;
            lock_q <= '0;
        end else begin
            fail_q <= fail_d;
            lock_q <= lock_d;
        end
    end
`endif

    assign tmo_hit = (tmo_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Session FSM; the idle timer only runs while staying in ONE, so entry restarts it.
    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        tmo_d   = '0;
`ifdef LOCKOUT_EN
        fail_d  = fail_q;
        lock_d  = '0;
        if (state_q == S_LOCKED) begin
            p1_d = '0;
            p2_d = '0;
            if (lock_q == LK_W'(LOCK_CYCLES - 1)) begin
                fail_d  = '0;
                state_d = sensor_entrance ? S_EMPTY : S_IDLE;
            end else begin
                lock_d = lock_q + LK_W'(1);
            end
        end else
`endif
        if (!sensor_entrance) begin
            state_d = S_IDLE;
            p1_d    = '0;
            p2_d    = '0;
        end else begin
`ifdef LOCKOUT_EN
            if (pass_accept) begin
                fail_d = '0;
            end
`endif
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_EMPTY;
                end
                S_EMPTY: begin
                    if (key_clear) begin
                        p1_d = '0;
                        p2_d = '0;
                    end else if (evt_q) begin
                        p1_d    = evt_code_q;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (key_clear || (!evt_q && tmo_hit)) begin
                        p1_d    = '0;
                        p2_d    = '0;
                        state_d = S_EMPTY;
                    end else if (evt_q) begin
                        p2_d    = evt_code_q;
                        state_d = S_READY;
                    end else begin
                        tmo_d = tmo_q + TO_W'(1);
                    end
                end
                S_READY: begin
                    if (key_clear) begin
                        p1_d    = '0;
                        p2_d    = '0;
                        state_d = S_EMPTY;
                    end else if (pass_reject) begin
                        p1_d    = '0;
                        p2_d    = '0;
                        state_d = S_EMPTY;
`ifdef LOCKOUT_EN
                        fail_d = fail_q + FAIL_W'(1);
                        if (fail_q == FAIL_W'(MAX_TRIES - 1)) begin
                            state_d = S_LOCKED;
                        end
`endif
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    p1_d    = '0;
                    p2_d    = '0;
                end
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_ONE:   digit_cnt = 2'd1;
            S_READY: digit_cnt = 2'd2;
            default: digit_cnt = 2'd0;
        endcase
    end

    assign pass1      = p1_q;
    assign pass2      = p2_q;
    assign pass_valid = (state_q == S_READY);
`ifdef LOCKOUT_EN
    assign locked     = (state_q == S_LOCKED);
`else
    assign locked     = 1'b0;
`endif

endmodule

// File: tb/tb_parking_pass_keypad.sv
// Testbench for parking_pass_keypad: op table, hand-written corner sequences, random run vs model.
module tb_parking_pass_keypad;
    localparam int DB = 4;
    localparam int TO = 64;
    localparam int MT = 3;
    localparam int LC = 128;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor_entrance = 1'b0;
    logic       key_press = 1'b0;
    logic [1:0] key_code = 2'd0;
    logic       key_clear = 1'b0;
    logic       pass_accept = 1'b0;
    logic       pass_reject = 1'b0;
    logic [1:0] pass1, pass2, digit_cnt;
    logic       pass_valid, locked;

    parking_pass_keypad #(
        .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .MAX_TRIES(MT), .LOCK_CYCLES(LC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sensor_entrance(sensor_entrance),
        .key_press(key_press), .key_code(key_code), .key_clear(key_clear),
        .pass_accept(pass_accept), .pass_reject(pass_reject),
        .pass1(pass1), .pass2(pass2), .pass_valid(pass_valid),
        .digit_cnt(digit_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: raw history queue for the synchroniser, run length of synced key,
    // list of captured digits, idle time with one digit, reject count and lock time left.
    logic [2:0] m_hist[$];
    int         m_run;
    bit         m_evt;
    logic [1:0] m_evt_code;
    bit         m_armed;
    logic [1:0] m_digits[$];
    int         m_idle;
    int         m_fails;
    int         m_lock_left;

    function automatic void model_reset();
        m_hist.delete();
        m_hist.push_back(3'b000);
        m_hist.push_back(3'b000);
        m_run = 0; m_evt = 0; m_evt_code = 2'd0; m_armed = 0;
        m_digits.delete();
        m_idle = 0; m_fails = 0; m_lock_left = 0;
    endfunction

    function automatic void model_step();
        logic [2:0] h;
        bit         new_evt;
        h = m_hist[0];
        new_evt = h[2] && (m_run == DB);
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_fails = 0;
                m_armed = sensor_entrance;
            end
        end else if (!sensor_entrance) begin
            m_armed = 0;
            m_digits.delete();
        end else begin
            if (pass_accept) m_fails = 0;
            if (!m_armed) m_armed = 1;
            else if (key_clear) m_digits.delete();
            else if (pass_reject && m_digits.size() == 2) begin
                m_digits.delete();
                m_fails++;
`ifdef LOCKOUT_EN
                if (m_fails == MT) m_lock_left = LC;
`endif
            end else if (m_evt && m_digits.size() < 2) begin
                m_digits.push_back(m_evt_code);
                m_idle = 0;
            end else if (m_digits.size() == 1) begin
                m_idle++;
                if (m_idle == TO) m_digits.delete();
            end
        end
        m_evt = new_evt;
        m_evt_code = h[1:0];
        void'(m_hist.pop_front());
        m_hist.push_back({key_press, key_code});
        h = m_hist[0];
        m_run = h[2] ? m_run + 1 : 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_model();
        logic [1:0] e1, e2;
        int n;
        n = m_digits.size();
        e1 = (n >= 1) ? m_digits[0] : 2'd0;
        e2 = (n == 2) ? m_digits[1] : 2'd0;
        check("mdl_pass1", pass1, e1);
        check("mdl_pass2", pass2, e2);
        check("mdl_valid", pass_valid, n == 2);
        check("mdl_cnt", digit_cnt, n);
        check("mdl_locked", locked, m_lock_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        sensor_entrance = 0; key_press = 0; key_clear = 0; pass_accept = 0; pass_reject = 0;
        #2 reset_n = 1'b0;
        #1 model_reset();
        check("rst_pass1", pass1, 0);
        check("rst_pass2", pass2, 0);
        check("rst_valid", pass_valid, 0);
        check("rst_cnt", digit_cnt, 0);
        check("rst_locked", locked, 0);
        #2 reset_n = 1'b1;
    endtask

    typedef enum int {OP_ARM, OP_DROP, OP_KEY, OP_GLITCH, OP_ACC, OP_REJ, OP_CLR} op_e;
    typedef struct {
        op_e        op;
        logic [1:0] code;
        logic [1:0] p1;
        logic [1:0] p2;
        logic       v;
        logic [1:0] cnt;
    } vec_t;

    task automatic apply_op(input op_e op, input logic [1:0] code);
        case (op)
            OP_ARM:    begin sensor_entrance = 1; repeat (2) tick(); end
            OP_DROP:   begin sensor_entrance = 0; repeat (2) tick(); end
            OP_KEY:    begin key_code = code; key_press = 1; repeat (8) tick();
                             key_press = 0; repeat (4) tick(); end
            OP_GLITCH: begin key_code = code; key_press = 1; repeat (2) tick();
                             key_press = 0; repeat (6) tick(); end
            OP_ACC:    begin pass_accept = 1; tick(); pass_accept = 0; tick(); end
            OP_REJ:    begin pass_reject = 1; tick(); pass_reject = 0; tick(); end
            OP_CLR:    begin key_clear = 1; tick(); key_clear = 0; tick(); end
            default:   tick();
        endcase
    endtask

    vec_t tbl[19];

    initial begin
        int press_left, gap_left, drop_left;
        bit found;

        model_reset();
        #2 reset_n = 1'b1;
        #1;
        check("init_pass1", pass1, 0);
        check("init_pass2", pass2, 0);
        check("init_valid", pass_valid, 0);
        check("init_cnt", digit_cnt, 0);
        check("init_locked", locked, 0);

        tbl[0]  = '{OP_ARM,    2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
        tbl[1]  = '{OP_GLITCH, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0};
        tbl[2]  = '{OP_KEY,    2'd1, 2'd1, 2'd0, 1'b0, 2'd1};
        tbl[3]  = '{OP_GLITCH, 2'd3, 2'd1, 2'd0, 1'b0, 2'd1};
        tbl[4]  = '{OP_KEY,    2'd2, 2'd1, 2'd2, 1'b1, 2'd2};
        tbl[5]  = '{OP_KEY,    2'd3, 2'd1, 2'd2, 1'b1, 2'd2};
        tbl[6]  = '{OP_ACC,    2'd0, 2'd1, 2'd2, 1'b1, 2'd2};
        tbl[7]  = '{OP_REJ,    2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
        tbl[8]  = '{OP_KEY,    2'd0, 2'd0, 2'd0, 1'b0, 2'd1};
        tbl[9]  = '{OP_KEY,    2'd1, 2'd0, 2'd1, 1'b1, 2'd2};
        tbl[10] = '{OP_REJ,    2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
        tbl[11] = '{OP_KEY,    2'd1, 2'd1, 2'd0, 1'b0, 2'd1};
        tbl[12] = '{OP_KEY,    2'd2, 2'd1, 2'd2, 1'b1, 2'd2};
        tbl[13] = '{OP_ACC,    2'd0, 2'd1, 2'd2, 1'b1, 2'd2};
        tbl[14] = '{OP_DROP,   2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
        tbl[15] = '{OP_ARM,    2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
        tbl[16] = '{OP_KEY,    2'd3, 2'd3, 2'd0, 1'b0, 2'd1};
        tbl[17] = '{OP_CLR,    2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
        tbl[18] = '{OP_KEY,    2'd2, 2'd2, 2'd0, 1'b0, 2'd1};

        for (int i = 0; i < 19; i++) begin
            apply_op(tbl[i].op, tbl[i].code);
            check($sformatf("tbl%0d_pass1", i), pass1, tbl[i].p1);
            check($sformatf("tbl%0d_pass2", i), pass2, tbl[i].p2);
            check($sformatf("tbl%0d_valid", i), pass_valid, tbl[i].v);
            check($sformatf("tbl%0d_cnt", i), digit_cnt, tbl[i].cnt);
        end

        // Capture latency: raw rise to digit update takes 2 + DB + 1 edges.
        do_reset();
        sensor_entrance = 1; repeat (2) tick();
        key_code = 2'd2; key_press = 1;
        repeat (2 + DB) tick();
        check("lat_early_cnt", digit_cnt, 0);
        tick();
        check("lat_cnt", digit_cnt, 1);
        check("lat_pass1", pass1, 2);
        key_press = 0; repeat (4) tick();

        // key_clear in the same cycle as a key event in ONE wins.
        key_code = 2'd1; key_press = 1;
        repeat (2 + DB) tick();
        key_clear = 1; tick(); key_clear = 0;
        check("clr_evt_cnt", digit_cnt, 0);
        check("clr_evt_pass1", pass1, 0);
        key_press = 0; repeat (4) tick();
        check("clr_evt_after", digit_cnt, 0);
        apply_op(OP_KEY, 2'd1);
        apply_op(OP_KEY, 2'd2);
        check("drop_pre_valid", pass_valid, 1);
        sensor_entrance = 0; tick();
        check("drop_valid", pass_valid, 0);
        check("drop_cnt", digit_cnt, 0);
        check("drop_pass1", pass1, 0);
        sensor_entrance = 1; tick();

        // Timeout in ONE after TO idle cycles.
        do_reset();
        sensor_entrance = 1; repeat (2) tick();
        key_code = 2'd3; key_press = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (digit_cnt == 2'd1) found = 1;
        end
        check("to_capture_seen", found, 1);
        key_press = 0;
        repeat (TO - 1) tick();
        check("to_before_cnt", digit_cnt, 1);
        check("to_before_pass1", pass1, 3);
        tick();
        check("to_cnt", digit_cnt, 0);
        check("to_pass1", pass1, 0);
        apply_op(OP_KEY, 2'd1);
        check("to_empty_cnt", digit_cnt, 1);

        // Three rejects.
        do_reset();
        sensor_entrance = 1; repeat (2) tick();
        for (int t = 0; t < MT; t++) begin
            apply_op(OP_KEY, 2'd1);
            apply_op(OP_KEY, 2'd2);
            pass_reject = 1; tick(); pass_reject = 0;
        end
`ifdef LOCKOUT_EN
        check("lock_on", locked, 1);
        apply_op(OP_KEY, 2'd3);
        check("lock_key_ignored", digit_cnt, 0);
        key_clear = 1; tick(); key_clear = 0;
        sensor_entrance = 0; repeat (3) tick(); sensor_entrance = 1;
        check("lock_sensor_hold", locked, 1);
        repeat (LC - 1 - 16) tick();
        check("lock_last", locked, 1);
        tick();
        check("lock_off", locked, 0);
        check("lock_off_cnt", digit_cnt, 0);
        apply_op(OP_KEY, 2'd3);
        check("lock_after_cnt", digit_cnt, 1);
        check("lock_after_pass1", pass1, 3);
`else
        check("nolock_after3", locked, 0);
        repeat (LC + 2) tick();
        check("nolock_later", locked, 0);
        apply_op(OP_KEY, 2'd3);
        check("nolock_retry_cnt", digit_cnt, 1);
`endif

        // Randomized run against the model.
        do_reset();
        sensor_entrance = 1;
        press_left = 0; gap_left = 3; drop_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (press_left > 0) begin
                press_left--;
                if (press_left == 0) key_press = 0;
            end else if (gap_left > 0) begin
                gap_left--;
            end else begin
                key_code   = 2'($urandom_range(0, 3));
                key_press  = 1;
                press_left = $urandom_range(1, 10);
                gap_left   = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 25);
            end
            if (drop_left > 0) begin
                drop_left--;
                sensor_entrance = (drop_left == 0);
            end else if ($urandom_range(0, 299) == 0) begin
                sensor_entrance = 0;
                drop_left = $urandom_range(1, 6);
            end
            key_clear   = ($urandom_range(0, 149) == 0);
            pass_reject = (m_digits.size() == 2 && m_lock_left == 0 && $urandom_range(0, 19) == 0);
            pass_accept = (!pass_reject && m_digits.size() == 2 && $urandom_range(0, 24) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
